// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcode and FSM state encodings,
// instruction field positions and an opcode-extract helper.
package seq_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned RETIRED_W = 16;
    localparam int unsigned OPC_W     = 3;
    localparam int unsigned OPC_LSB   = 29;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 3'b000,
        OP_ALU  = 3'b001,
        OP_LW   = 3'b010,
        OP_SW   = 3'b011,
        OP_BEQ  = 3'b100,
        OP_JMP  = 3'b101,
        OP_HALT = 3'b110,
        OP_ILL  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    // Opcode lives in the top three bits of the instruction word.
    function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[OPC_LSB +: OPC_W]);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-wait watchdog for the instruction sequencer.
// Ports: clk, reset (async, active-high); waiting_i (FSM in FETCH or MEM);
//        ack_i (the ack relevant to the current wait state);
//        expired_c (combinational: this wait cycle is the LIMIT-th one).
module seq_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting_i,
    input  logic ack_i,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count only consecutive un-acked wait cycles; anything else restarts the
    // count, so every entry into FETCH or MEM begins at zero.
    always_comb begin
        count_d = '0;
        if (waiting_i && !ack_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the LIMIT-th wait cycle regardless of a same-cycle ack.
    assign expired_c = waiting_i && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Ports: clk, reset (async, active-high); start; imem_req/imem_ack/instr
//        fetch handshake; ir_load, alu_en, alu_zero; dmem_req/dmem_we/dmem_ack
//        data handshake; reg_write_enable, pc_inc, branch_take strobes;
//        retired (instruction count), halted, err (sticky, registered).
// Strobes and requests are combinational decodes of state and inputs.
// Build option: CTRL_TIMEOUT_EN enables the MEM_TIMEOUT wait watchdog.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 ir_load,
    output logic                 alu_en,
    input  logic                 alu_zero,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 reg_write_enable,
    output logic                 pc_inc,
    output logic                 branch_take,
    output logic [RETIRED_W-1:0] retired,
    output logic                 halted,
    output logic                 err
);

    if (MEM_TIMEOUT < 1) begin : g_timeout_range_check
        $error("MEM_TIMEOUT must be at least 1");
    end

    state_e                 state_q, state_d;
    opcode_e                op_q, op_d;
    logic [RETIRED_W-1:0]   retired_q;
    logic                   halted_q;
    logic                   err_q;
    logic                   timeout_c;

`ifdef CTRL_TIMEOUT_EN
    logic waiting_c;
    logic wait_ack_c;

    assign waiting_c  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_ack_c = (state_q == S_FETCH) ? imem_ack : dmem_ack;

    seq_wait_timer #(
        .LIMIT     (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .waiting_i (waiting_c),
        .ack_i     (wait_ack_c),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and strobe decode.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        imem_req         = 1'b0;
        ir_load          = 1'b0;
        alu_en           = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        reg_write_enable = 1'b0;
        pc_inc           = 1'b0;
        branch_take      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (timeout_c) begin
                    state_d = S_ERR;
                end else if (imem_ack) begin
                    ir_load = 1'b1;
                    op_d    = get_opcode(instr);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (op_q)
                    OP_NOP: begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_ALU, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
                    OP_JMP: begin
                        branch_take = 1'b1;
                        state_d     = S_FETCH;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_ERR;
                endcase
            end
            S_EXEC: begin
                alu_en = 1'b1;
                unique case (op_q)
                    OP_ALU:       state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        branch_take = alu_zero;
                        pc_inc      = !alu_zero;
                        state_d     = S_FETCH;
                    end
                    default:      state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_SW);
                if (timeout_c) begin
                    state_d = S_ERR;
                end else if (dmem_ack) begin
                    // Stores finish here; loads still owe a register write.
                    if (op_q == OP_SW) begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_enable = 1'b1;
                pc_inc           = 1'b1;
                state_d          = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_ERR;
        endcase
    end

    // State, latched opcode, retire count and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            retired_q <= '0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            halted_q  <= (state_d == S_HALT);
            err_q     <= (state_d == S_ERR);
            if (pc_inc || branch_take) begin
                retired_q <= retired_q + RETIRED_W'(1);
            end
        end
    end

    assign retired = retired_q;
    assign halted  = halted_q;
    assign err     = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer. A per-instruction model
// expands each opcode into its expected cycle-by-cycle strobe trace.
module tb_instr_sequencer;

    localparam int unsigned TO = 4;
`ifdef CTRL_TIMEOUT_EN
    localparam int MAXW = TO - 2;
`else
    localparam int MAXW = 3;
`endif

    localparam logic [2:0] NOP = 3'd0, ALU = 3'd1, LW = 3'd2, SW = 3'd3,
                           BEQ = 3'd4, JMP = 3'd5, HLT = 3'd6, ILL = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imem_req, ir_load, alu_en, dmem_req, dmem_we;
    logic        reg_write_enable, pc_inc, branch_take, halted, err;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] instr = '0;
    logic [15:0] retired;

    instr_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
        .ir_load(ir_load), .alu_en(alu_en), .alu_zero(alu_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_write_enable(reg_write_enable), .pc_inc(pc_inc),
        .branch_take(branch_take), .retired(retired),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rtd    = 0;

    // Expected per-cycle outputs and the stimulus that goes with them.
    logic [9:0]  exp_q[$];
    logic [15:0] ret_q[$];
    logic        ia_q[$], da_q[$], z_q[$];
    logic [31:0] ins_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] outs();
        return {imem_req, ir_load, alu_en, dmem_req, dmem_we,
                reg_write_enable, pc_inc, branch_take, halted, err};
    endfunction

    // Field order: imem_req ir_load alu_en dmem_req dmem_we rwe pc_inc bt halted err
    function automatic logic [9:0] v(input bit ireq, ild, alu, dreq, dwe, rwe, pci, bt, hl, er);
        return {ireq, ild, alu, dreq, dwe, rwe, pci, bt, hl, er};
    endfunction

    task automatic push(input logic [9:0] e, input logic ia, input logic da,
                        input logic z, input logic [31:0] ins, input bit retire);
        exp_q.push_back(e);
        ret_q.push_back(16'(rtd));
        ia_q.push_back(ia);
        da_q.push_back(da);
        z_q.push_back(z);
        ins_q.push_back(ins);
        if (retire) rtd = (rtd + 1) & 32'hFFFF;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Expand one instruction into its trace: fd fetch-wait cycles, md memory-wait
    // cycles, z the ALU zero flag seen by a BEQ.
    task automatic build(input logic [2:0] op, input int fd, input int md, input logic z);
        logic [31:0] ins;
        ins = {op, 29'($urandom)};
        for (int i = 0; i < fd; i++) push(v(1,0,0,0,0,0,0,0,0,0), 1'b0, rb(), rb(), $urandom, 0);
        push(v(1,1,0,0,0,0,0,0,0,0), 1'b1, rb(), rb(), ins, 0);
        case (op)
            NOP: push(v(0,0,0,0,0,0,1,0,0,0), rb(), rb(), rb(), $urandom, 1);
            JMP: push(v(0,0,0,0,0,0,0,1,0,0), rb(), rb(), rb(), $urandom, 1);
            default: push(v(0,0,0,0,0,0,0,0,0,0), rb(), rb(), rb(), $urandom, 0);
        endcase
        if (op == ALU || op == LW || op == SW) push(v(0,0,1,0,0,0,0,0,0,0), rb(), rb(), rb(), $urandom, 0);
        if (op == BEQ) push(v(0,0,1,0,0,0,!z,z,0,0), rb(), rb(), z, $urandom, 1);
        if (op == LW || op == SW) begin
            for (int i = 0; i < md; i++) push(v(0,0,0,1,op == SW,0,0,0,0,0), rb(), 1'b0, rb(), $urandom, 0);
            push(v(0,0,0,1,op == SW,0,op == SW,0,0,0), rb(), 1'b1, rb(), $urandom, op == SW);
        end
        if (op == ALU || op == LW) push(v(0,0,0,0,0,1,1,0,0,0), rb(), rb(), rb(), $urandom, 1);
    endtask

    task automatic terminal(input bit is_halt, input int n);
        for (int i = 0; i < n; i++) push(v(0,0,0,0,0,0,0,0,is_halt,!is_halt), rb(), rb(), rb(), $urandom, 0);
    endtask

    // Replay up to n queued cycles: drive at negedge, check 1ns later.
    task automatic play(input int n);
        int k = 0;
        while (exp_q.size() > 0 && k < n) begin
            @(negedge clk);
            imem_ack = ia_q.pop_front();
            dmem_ack = da_q.pop_front();
            alu_zero = z_q.pop_front();
            instr    = ins_q.pop_front();
            start    = rb();
            #1;
            check_eq("cycle", {6'd0, retired, outs()}, {6'd0, ret_q.pop_front(), exp_q.pop_front()});
            k++;
        end
        start = 1'b0;
    endtask

    task automatic flush_model();
        exp_q.delete(); ret_q.delete(); ia_q.delete();
        da_q.delete(); z_q.delete(); ins_q.delete();
        rtd = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        #1;
        check_eq("reset", {retired, outs()}, 26'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        flush_model();
        // IDLE ignores stray acks and stays quiet without start.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_ack = rb();
            dmem_ack = rb();
            #1;
            check_eq("idle", {retired, outs()}, 26'd0);
        end
    endtask

    task automatic idle_start();
        @(negedge clk);
        start    = 1'b1;
        imem_ack = rb();
        #1;
        check_eq("idle_start", {6'd0, retired, outs()}, {6'd0, 16'(rtd), 10'd0});
    endtask

    initial begin
        #3;
        check_eq("reset_init", {retired, outs()}, 26'd0);
        do_reset();
        idle_start();

        // Directed: ALU fast fetch, LW with late ack, BEQ taken/not taken.
        build(ALU, 0, 0, 1'b0);        play(100);
        build(LW, 0, MAXW, 1'b0);      play(100);
        build(BEQ, 1, 0, 1'b1);        play(100);
        build(BEQ, 0, 0, 1'b0);        play(100);
        build(NOP, 0, 0, 1'b0);        play(100);
        build(JMP, 2, 0, 1'b0);        play(100);
        build(SW, 1, 1, 1'b0);         play(100);

        // Random mix of non-terminal opcodes and wait lengths.
        for (int i = 0; i < 60; i++) begin
            build(3'($urandom_range(0, 5)), $urandom_range(0, MAXW), $urandom_range(0, MAXW), rb());
            play(100);
        end

        // HALT is terminal; start and acks are ignored.
        build(HLT, 0, 0, 1'b0);
        terminal(1'b1, 10);
        play(100);
        do_reset();
        idle_start();

        // Reset in the middle of a store drops the request immediately.
        build(ALU, 0, 0, 1'b0);        play(100);
        build(SW, 0, 5, 1'b0);
        play(4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst", {retired, outs()}, 26'd0);
        @(negedge clk);
        reset = 1'b0;
        flush_model();
        idle_start();

        // Illegal opcode lands in ERR and stays.
        build(NOP, 0, 0, 1'b0);        play(100);
        build(ILL, 1, 0, 1'b0);
        terminal(1'b0, 6);
        play(100);
        do_reset();
        idle_start();

        // Fetch with no acknowledge.
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++)
            push(v(1,0,0,0,0,0,0,0,0,0), i == int'(TO) - 1, rb(), rb(), $urandom, 0);
        terminal(1'b0, 5);
`else
        for (int i = 0; i < 100; i++) push(v(1,0,0,0,0,0,0,0,0,0), 1'b0, rb(), rb(), $urandom, 0);
`endif
        play(200);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
